// File: rtl/register_file_16x32.sv
// Sixteen-entry register file with one write port and two combinational read ports.
// R15 is also the program counter and has its own increment path next to the write port.
module register_file_16x32 #(
  parameter int WIDTH   = 32,
  parameter int PC_STEP = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             RegWrite,
  input  logic [3:0]       WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [3:0]       RA,
  input  logic [3:0]       RB,
  input  logic             PcInc,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic [WIDTH-1:0] PC
);

  localparam int NREGS  = 16;
  localparam int PC_IDX = 15;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] w_wr_sel;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_qa;
  logic [WIDTH-1:0] w_qb;

  // One-hot write decode; a zero vector when the write port is idle.
  always_comb begin
    w_wr_sel = '0;
    if (RegWrite) begin
      w_wr_sel[WA] = 1'b1;
    end
  end

  // Increment wraps naturally at 2^WIDTH, with no carry out kept.
  assign w_pc_next = r_regs[PC_IDX] + WIDTH'(PC_STEP);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (w_wr_sel[i]) begin
          r_regs[i] <= WD;
        end
      end
      // An explicit write to R15 takes priority over the increment on the same edge.
      if (w_wr_sel[PC_IDX]) begin
        r_regs[PC_IDX] <= WD;
      end else if (PcInc) begin
        r_regs[PC_IDX] <= w_pc_next;
      end
    end
  end

  // Read ports come straight from the stored state: no write-through bypass.
  always_comb begin
    w_qa = r_regs[RA];
    w_qb = r_regs[RB];
  end

  assign QA = w_qa;
  assign QB = w_qb;
  assign PC = r_regs[PC_IDX];

endmodule
